// File: rtl/monitor_temperatura_param.sv
// Temperature supervisor: samples a W-bit temperature on a read-strobe edge,
// drives a fan with hysteresis, raises a qualified alarm after N consecutive
// over-threshold samples, and scans a 4-digit 7-segment display.
module monitor_temperatura_param #(
   parameter int W           = 5,
   parameter int T_VENT_ON   = 25,
   parameter int T_VENT_OFF  = 22,
   parameter int T_ALARMA    = 28,
   parameter int N_ALARMA    = 2,
   parameter int REFRESH_DIV = 50000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] temperatura,
   input  logic         en_m1,
   input  logic         lect,
   output logic         est_alarma,
   output logic         est_ventilador,
   output logic [3:0]   anodos,
   output logic [7:0]   catodos
);

   localparam logic [W-1:0] TH_ON_C     = W'(T_VENT_ON);
   localparam logic [W-1:0] TH_OFF_C    = W'(T_VENT_OFF);
   localparam logic [W-1:0] TH_ALARMA_C = W'(T_ALARMA);
   // One degree of hysteresis before leaving the alarm state
   localparam logic [W-1:0] TH_HIST_C   = W'(T_ALARMA - 1);
   localparam logic [3:0]   N_C         = 4'(N_ALARMA);
   localparam int           CNT_W       = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      ST_NORMAL     = 2'd0,
      ST_PRE_ALARMA = 2'd1,
      ST_ALARMA     = 2'd2
   } alarm_state_t;

   alarm_state_t     state_r, state_nx_s;
   logic [3:0]       count_r, count_nx_s;
   logic             lect_d_r;
   logic             accept_s;
   logic             over_s;
   logic [W-1:0]     temp_lat_r;
   logic             est_alarma_r, alarma_nx_s;
   logic             est_ventilador_r, vent_nx_s;
   logic [CNT_W-1:0] refresh_cnt_r;
   logic [1:0]       digit_idx_r;
   logic [3:0]       anodos_r, anodos_nx_s;
   logic [7:0]       catodos_r, catodos_nx_s;
   logic [6:0]       val_s;
   logic [3:0]       units_s, tens_s, hund_s;

   // Active-low segment pattern {dp,g,f,e,d,c,b,a} for a decimal digit
   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // Only the enabled 0->1 transition of the strobe takes a sample
   assign accept_s = en_m1 & lect & ~lect_d_r;
   assign over_s   = (temperatura >= TH_ALARMA_C);

   // Fan hysteresis decision for the incoming sample
   always_comb begin
      vent_nx_s = est_ventilador_r;
      if (accept_s) begin
         if (temperatura >= TH_ON_C) begin
            vent_nx_s = 1'b1;
         end else if (temperatura <= TH_OFF_C) begin
            vent_nx_s = 1'b0;
         end else begin
            vent_nx_s = est_ventilador_r;
         end
      end else begin
         vent_nx_s = est_ventilador_r;
      end
   end

   // Alarm qualification FSM: next state, over-count and alarm flag
   always_comb begin
      state_nx_s  = state_r;
      count_nx_s  = count_r;
      alarma_nx_s = est_alarma_r;
      if (accept_s) begin
         case (state_r)
            ST_NORMAL: begin
               if (over_s) begin
                  count_nx_s = 4'd1;
                  if (N_C <= 4'd1) begin
                     state_nx_s  = ST_ALARMA;
                     alarma_nx_s = 1'b1;
                  end else begin
                     state_nx_s  = ST_PRE_ALARMA;
                     alarma_nx_s = 1'b0;
                  end
               end else begin
                  state_nx_s  = ST_NORMAL;
                  count_nx_s  = 4'd0;
                  alarma_nx_s = 1'b0;
               end
            end
            ST_PRE_ALARMA: begin
               if (over_s) begin
                  if ((count_r + 4'd1) >= N_C) begin
                     state_nx_s  = ST_ALARMA;
                     count_nx_s  = N_C;
                     alarma_nx_s = 1'b1;
                  end else begin
                     state_nx_s  = ST_PRE_ALARMA;
                     count_nx_s  = count_r + 4'd1;
                     alarma_nx_s = 1'b0;
                  end
               end else begin
                  state_nx_s  = ST_NORMAL;
                  count_nx_s  = 4'd0;
                  alarma_nx_s = 1'b0;
               end
            end
            ST_ALARMA: begin
               if (temperatura >= TH_HIST_C) begin
                  state_nx_s  = ST_ALARMA;
                  count_nx_s  = count_r;
                  alarma_nx_s = 1'b1;
               end else begin
                  state_nx_s  = ST_NORMAL;
                  count_nx_s  = 4'd0;
                  alarma_nx_s = 1'b0;
               end
            end
            default: begin
               state_nx_s  = ST_NORMAL;
               count_nx_s  = 4'd0;
               alarma_nx_s = 1'b0;
            end
         endcase
      end else begin
         state_nx_s  = state_r;
         count_nx_s  = count_r;
         alarma_nx_s = est_alarma_r;
      end
   end

   // Sample latch, strobe edge register, FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         lect_d_r         <= 1'b0;
         temp_lat_r       <= '0;
         state_r          <= ST_NORMAL;
         count_r          <= 4'd0;
         est_alarma_r     <= 1'b0;
         est_ventilador_r <= 1'b0;
      end else begin
         lect_d_r         <= lect;
         if (accept_s) begin
            temp_lat_r <= temperatura;
         end
         state_r          <= state_nx_s;
         count_r          <= count_nx_s;
         est_alarma_r     <= alarma_nx_s;
         est_ventilador_r <= vent_nx_s;
      end
   end

   // Decimal split of the latched value (at most 127)
   assign val_s   = 7'(temp_lat_r);
   assign hund_s  = 4'(val_s / 7'd100);
   assign tens_s  = 4'((val_s / 7'd10) % 7'd10);
   assign units_s = 4'(val_s % 7'd10);

   // Digit select and segment pattern for the digit currently scanned
   always_comb begin
      anodos_nx_s  = ~(4'b0001 << digit_idx_r);
      catodos_nx_s = 8'hFF;
      case (digit_idx_r)
         2'd0: catodos_nx_s = seg7(units_s);
         2'd1: begin
            if ((hund_s == 4'd0) && (tens_s == 4'd0)) begin
               catodos_nx_s = 8'hFF;
            end else begin
               catodos_nx_s = seg7(tens_s);
            end
         end
         2'd2: begin
            if (hund_s == 4'd0) begin
               catodos_nx_s = 8'hFF;
            end else begin
               catodos_nx_s = seg7(hund_s);
            end
         end
         2'd3: begin
            if (est_alarma_r) begin
               catodos_nx_s = 8'b1000_1000;
            end else if (est_ventilador_r) begin
               catodos_nx_s = 8'b1000_1110;
            end else begin
               catodos_nx_s = 8'hFF;
            end
         end
         default: catodos_nx_s = 8'hFF;
      endcase
   end

   // Refresh timer, digit index and registered display drive
   always_ff @(posedge clk) begin
      if (reset) begin
         refresh_cnt_r <= '0;
         digit_idx_r   <= 2'd0;
         anodos_r      <= 4'b1111;
         catodos_r     <= 8'hFF;
      end else begin
         if (refresh_cnt_r == CNT_MAX_C) begin
            refresh_cnt_r <= '0;
            digit_idx_r   <= digit_idx_r + 2'd1;
         end else begin
            refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
         end
         anodos_r  <= anodos_nx_s;
         catodos_r <= catodos_nx_s;
      end
   end

   assign est_alarma     = est_alarma_r;
   assign est_ventilador = est_ventilador_r;
   assign anodos         = anodos_r;
   assign catodos        = catodos_r;

endmodule

// File: tb/tb_monitor_temperatura_param.sv
// Directed bench for monitor_temperatura_param with a short refresh period.
module tb_monitor_temperatura_param;

   localparam int REF = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] temperatura;
   logic       en_m1;
   logic       lect;
   logic       est_alarma;
   logic       est_ventilador;
   logic [3:0] anodos;
   logic [7:0] catodos;

   int n_checks = 0;
   int n_fail   = 0;

   monitor_temperatura_param #(
      .W(5), .T_VENT_ON(25), .T_VENT_OFF(22), .T_ALARMA(28),
      .N_ALARMA(2), .REFRESH_DIV(REF)
   ) dut (
      .clk(clk), .reset(reset), .temperatura(temperatura), .en_m1(en_m1),
      .lect(lect), .est_alarma(est_alarma), .est_ventilador(est_ventilador),
      .anodos(anodos), .catodos(catodos)
   );

   always #5 clk = ~clk;

   task automatic send_sample(input logic [4:0] v);
      @(negedge clk);
      temperatura = v;
      lect = 1'b1;
      @(negedge clk);
      lect = 1'b0;
   endtask

   // Wait (bounded) for a digit to be selected and capture its segments; X on timeout
   task automatic read_digit(input int d, output logic [7:0] seg);
      logic [3:0] mask;
      bit found;
      mask  = ~(4'b0001 << d);
      seg   = 8'hxx;
      found = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (anodos === mask) begin
            seg   = catodos;
            found = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      logic [3:0] exp_an;
      reset = 1'b1; en_m1 = 1'b1; lect = 1'b0; temperatura = 5'd0;
      repeat (5) @(negedge clk);
      n_checks++; if (est_alarma !== 1'b0) begin n_fail++; $display("FAIL reset_alarma: got %b expected 0", est_alarma); end
      n_checks++; if (est_ventilador !== 1'b0) begin n_fail++; $display("FAIL reset_fan: got %b expected 0", est_ventilador); end
      n_checks++; if (anodos !== 4'b1111) begin n_fail++; $display("FAIL reset_anodos: got %b expected 1111", anodos); end
      n_checks++; if (catodos !== 8'hFF) begin n_fail++; $display("FAIL reset_catodos: got %h expected ff", catodos); end
      reset = 1'b0;
      #1;
      n_checks++; if (anodos !== 4'b1111) begin n_fail++; $display("FAIL release_anodos: got %b expected 1111", anodos); end
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         exp_an = ~(4'b0001 << (k / 4));
         n_checks++;
         if (anodos !== exp_an) begin
            n_fail++;
            $display("FAIL scan[%0d]: got %b expected %b", k, anodos, exp_an);
         end
      end
   endtask

   task automatic test_fan;
      logic [4:0] vals [5];
      logic       expv [5];
      logic       prev;
      vals = '{5'd20, 5'd25, 5'd23, 5'd22, 5'd26};
      expv = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      prev = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         temperatura = vals[i];
         lect = 1'b1;
         #1;
         n_checks++;
         if (est_ventilador !== prev) begin
            n_fail++; $display("FAIL fan_pre[%0d]: got %b expected %b", i, est_ventilador, prev);
         end
         @(negedge clk);
         lect = 1'b0;
         n_checks++;
         if (est_ventilador !== expv[i]) begin
            n_fail++; $display("FAIL fan[%0d] temp=%0d: got %b expected %b", i, vals[i], est_ventilador, expv[i]);
         end
         prev = expv[i];
      end
   endtask

   task automatic test_alarm;
      logic [4:0] vals [6];
      logic       expv [6];
      vals = '{5'd28, 5'd27, 5'd28, 5'd29, 5'd27, 5'd26};
      expv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         send_sample(vals[i]);
         n_checks++;
         if (est_alarma !== expv[i]) begin
            n_fail++; $display("FAIL alarm[%0d] temp=%0d: got %b expected %b", i, vals[i], est_alarma, expv[i]);
         end
      end
   endtask

   task automatic test_strobe;
      logic [7:0] seg;
      @(negedge clk);
      en_m1 = 1'b1; temperatura = 5'd12; lect = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         temperatura = 5'd30;
      end
      n_checks++; if (est_ventilador !== 1'b0) begin n_fail++; $display("FAIL held_fan: got %b expected 0", est_ventilador); end
      n_checks++; if (est_alarma !== 1'b0) begin n_fail++; $display("FAIL held_alarma: got %b expected 0", est_alarma); end
      @(negedge clk);
      lect = 1'b0;
      read_digit(0, seg);
      n_checks++; if (seg !== 8'hA4) begin n_fail++; $display("FAIL held_digit0: got %h expected a4", seg); end
      read_digit(1, seg);
      n_checks++; if (seg !== 8'hF9) begin n_fail++; $display("FAIL held_digit1: got %h expected f9", seg); end
      // Strobe while disabled is lost
      @(negedge clk);
      en_m1 = 1'b0; temperatura = 5'd30; lect = 1'b1;
      @(negedge clk);
      lect = 1'b0;
      @(negedge clk);
      n_checks++; if (est_ventilador !== 1'b0) begin n_fail++; $display("FAIL disabled_fan: got %b expected 0", est_ventilador); end
      read_digit(0, seg);
      n_checks++; if (seg !== 8'hA4) begin n_fail++; $display("FAIL disabled_digit0: got %h expected a4", seg); end
      // Enable rising while strobe already high is not an edge
      @(negedge clk);
      lect = 1'b1;
      @(negedge clk);
      en_m1 = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (est_ventilador !== 1'b0) begin n_fail++; $display("FAIL late_enable_fan: got %b expected 0", est_ventilador); end
      lect = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_display;
      logic [7:0] seg;
      send_sample(5'd28);
      send_sample(5'd28);
      n_checks++; if (est_alarma !== 1'b1) begin n_fail++; $display("FAIL disp_alarma: got %b expected 1", est_alarma); end
      read_digit(0, seg);
      n_checks++; if (seg !== 8'h80) begin n_fail++; $display("FAIL d28_digit0: got %h expected 80", seg); end
      read_digit(1, seg);
      n_checks++; if (seg !== 8'hA4) begin n_fail++; $display("FAIL d28_digit1: got %h expected a4", seg); end
      read_digit(2, seg);
      n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL d28_digit2: got %h expected ff", seg); end
      read_digit(3, seg);
      n_checks++; if (seg !== 8'h88) begin n_fail++; $display("FAIL d28_digit3: got %h expected 88", seg); end
      send_sample(5'd5);
      read_digit(0, seg);
      n_checks++; if (seg !== 8'h92) begin n_fail++; $display("FAIL d5_digit0: got %h expected 92", seg); end
      read_digit(1, seg);
      n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL d5_digit1: got %h expected ff", seg); end
      read_digit(3, seg);
      n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL d5_digit3: got %h expected ff", seg); end
      send_sample(5'd25);
      read_digit(3, seg);
      n_checks++; if (seg !== 8'h8E) begin n_fail++; $display("FAIL d25_digit3: got %h expected 8e", seg); end
      read_digit(1, seg);
      n_checks++; if (seg !== 8'hA4) begin n_fail++; $display("FAIL d25_digit1: got %h expected a4", seg); end
   endtask

   task automatic test_reset_with_strobe;
      logic [7:0] seg;
      @(negedge clk);
      reset = 1'b1; temperatura = 5'd30; lect = 1'b1;
      @(negedge clk);
      n_checks++; if (est_alarma !== 1'b0) begin n_fail++; $display("FAIL rs_alarma: got %b expected 0", est_alarma); end
      n_checks++; if (est_ventilador !== 1'b0) begin n_fail++; $display("FAIL rs_fan: got %b expected 0", est_ventilador); end
      n_checks++; if (dut.temp_lat_r !== 5'd0) begin n_fail++; $display("FAIL rs_temp_lat: got %0d expected 0", dut.temp_lat_r); end
      n_checks++; if (anodos !== 4'b1111) begin n_fail++; $display("FAIL rs_anodos: got %b expected 1111", anodos); end
      reset = 1'b0; lect = 1'b0;
      @(negedge clk);
      n_checks++; if (est_ventilador !== 1'b0) begin n_fail++; $display("FAIL rs_after_fan: got %b expected 0", est_ventilador); end
      read_digit(0, seg);
      n_checks++; if (seg !== 8'hC0) begin n_fail++; $display("FAIL rs_digit0: got %h expected c0", seg); end
      read_digit(1, seg);
      n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL rs_digit1: got %h expected ff", seg); end
      send_sample(5'd30);
      n_checks++; if (est_ventilador !== 1'b1) begin n_fail++; $display("FAIL rs_resume_fan: got %b expected 1", est_ventilador); end
      n_checks++; if (est_alarma !== 1'b0) begin n_fail++; $display("FAIL rs_resume_alarma: got %b expected 0", est_alarma); end
   endtask

   initial begin
      test_reset();
      test_fan();
      test_alarm();
      test_strobe();
      test_display();
      test_reset_with_strobe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
